// File: rtl/timer_pkg.sv
// Shared definitions for the match timer: per-channel match-control field layout.
package timer_pkg;

    localparam int unsigned MCR_W    = 3;
    localparam int unsigned MCR_INT  = 0;
    localparam int unsigned MCR_RST  = 1;
    localparam int unsigned MCR_STOP = 2;

endpackage

// File: rtl/match_channel.sv
// One match channel: compares TC on tick cycles, emits rst/stop actions, owns its sticky ir flag.
module match_channel
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] tc_i,
    input  logic [CNT_W-1:0] mr_i,
    input  logic [MCR_W-1:0] mcr_i,
    input  logic             tick_i,
    input  logic             ir_clr_i,
    output logic             match_rst_c,
    output logic             match_stop_c,
    output logic             ir_o
);

    logic hit_c;
    logic ir_d;
    logic ir_q;

    assign hit_c        = tick_i && (tc_i == mr_i);
    assign match_rst_c  = hit_c && mcr_i[MCR_RST];
    assign match_stop_c = hit_c && mcr_i[MCR_STOP];

    // Set beats clear when both land in the same cycle.
    always_comb begin
        ir_d = ir_q;
        if (ir_clr_i) ir_d = 1'b0;
        if (hit_c && mcr_i[MCR_INT]) ir_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ir_q <= 1'b0;
        else       ir_q <= ir_d;
    end

    assign ir_o = ir_q;

endmodule

// File: rtl/match_timer_n.sv
// Prescaled match timer with NUM_MATCH channels, sticky interrupt/overflow flags and run control.
module match_timer_n
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned NUM_MATCH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       ctr_clr,
    input  logic [CNT_W-1:0]           pr_val,
    input  logic [NUM_MATCH*CNT_W-1:0] mr_val,
    input  logic [NUM_MATCH*MCR_W-1:0] mcr,
    input  logic [NUM_MATCH-1:0]       ir_clr,
    input  logic                       ovf_clr,
    output logic [CNT_W-1:0]           tc,
    output logic [CNT_W-1:0]           pc,
    output logic [NUM_MATCH-1:0]       ir,
    output logic                       ovf,
    output logic                       irq,
    output logic                       running
);

    logic [CNT_W-1:0]     tc_q, tc_d;
    logic [CNT_W-1:0]     pc_q, pc_d;
    logic                 running_q, running_d;
    logic                 ovf_q, ovf_d;
    logic                 tick_c;
    logic                 any_rst_c;
    logic                 any_stop_c;
    logic                 wrap_c;
    logic [NUM_MATCH-1:0] rst_v;
    logic [NUM_MATCH-1:0] stop_v;
    logic [NUM_MATCH-1:0] ir_v;

    assign tick_c = running_q && (pc_q == pr_val);

    for (genvar n = 0; n < NUM_MATCH; n++) begin : g_ch
        match_channel #(.CNT_W(CNT_W)) u_ch (
            .clk         (clk),
            .reset       (reset),
            .tc_i        (tc_q),
            .mr_i        (mr_val[n*CNT_W +: CNT_W]),
            .mcr_i       (mcr[n*MCR_W +: MCR_W]),
            .tick_i      (tick_c),
            .ir_clr_i    (ir_clr[n]),
            .match_rst_c (rst_v[n]),
            .match_stop_c(stop_v[n]),
            .ir_o        (ir_v[n])
        );
    end

    assign any_rst_c  = |rst_v;
    assign any_stop_c = |stop_v;
    // Only a natural all-ones -> 0 increment counts as overflow; match-reset and ctr_clr do not.
    assign wrap_c     = tick_c && !any_rst_c && !ctr_clr && (tc_q == {CNT_W{1'b1}});

    always_comb begin
        tc_d      = tc_q;
        pc_d      = pc_q;
        running_d = running_q;
        ovf_d     = ovf_q;

        if (running_q) begin
            if (tick_c) pc_d = '0;
            else        pc_d = pc_q + CNT_W'(1);
        end
        if (tick_c) begin
            if (any_rst_c) tc_d = '0;
            else           tc_d = tc_q + CNT_W'(1);
        end
        if (ctr_clr) begin
            tc_d = '0;
            pc_d = '0;
        end

        if (stop || any_stop_c) running_d = 1'b0;
        else if (start)         running_d = 1'b1;

        if (ovf_clr) ovf_d = 1'b0;
        if (wrap_c)  ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tc_q      <= '0;
            pc_q      <= '0;
            running_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            tc_q      <= tc_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tc      = tc_q;
    assign pc      = pc_q;
    assign ir      = ir_v;
    assign ovf     = ovf_q;
    assign running = running_q;
    assign irq     = (|ir_v) | ovf_q;

endmodule

// File: tb/tb_match_timer_n.sv
// Bench for match_timer_n: directed scenarios plus randomized run against a behavioural model.
module tb_match_timer_n;

    localparam int CW = 8;
    localparam int NM = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             ctr_clr = 1'b0;
    logic [CW-1:0]    pr_val = '0;
    logic [NM*CW-1:0] mr_val = '0;
    logic [NM*3-1:0]  mcr = '0;
    logic [NM-1:0]    ir_clr = '0;
    logic             ovf_clr = 1'b0;
    logic [CW-1:0]    tc;
    logic [CW-1:0]    pc;
    logic [NM-1:0]    ir;
    logic             ovf;
    logic             irq;
    logic             running;

    int checks = 0;
    int failures = 0;

    match_timer_n #(.CNT_W(CW), .NUM_MATCH(NM)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .ctr_clr(ctr_clr),
        .pr_val(pr_val), .mr_val(mr_val), .mcr(mcr), .ir_clr(ir_clr), .ovf_clr(ovf_clr),
        .tc(tc), .pc(pc), .ir(ir), .ovf(ovf), .irq(irq), .running(running)
    );

    always #5 clk = ~clk;

    // Behavioural model: counters as plain integers, applied rule by rule.
    typedef struct {
        int         tc;
        int         pc;
        bit         run;
        bit         ovf;
        bit [NM-1:0] ir;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t s);
        mstate_t r = s;
        bit tk = s.run && (s.pc == int'(pr_val));
        bit do_rst = 1'b0;
        bit do_stop = 1'b0;
        r.ir = s.ir & ~ir_clr;
        for (int n = 0; n < NM; n++) begin
            if (tk && s.tc == int'(mr_val[n*CW +: CW])) begin
                if (mcr[n*3])     r.ir[n] = 1'b1;
                if (mcr[n*3 + 1]) do_rst = 1'b1;
                if (mcr[n*3 + 2]) do_stop = 1'b1;
            end
        end
        if (tk && !do_rst && !ctr_clr && s.tc == (1 << CW) - 1) r.ovf = 1'b1;
        else if (ovf_clr)                                       r.ovf = 1'b0;
        if (ctr_clr) begin
            r.tc = 0;
            r.pc = 0;
        end else if (tk) begin
            r.tc = do_rst ? 0 : (s.tc + 1) % (1 << CW);
            r.pc = 0;
        end else if (s.run) begin
            r.pc = (s.pc + 1) % (1 << CW);
        end
        if (stop || do_stop) r.run = 1'b0;
        else if (start)      r.run = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '{tc: 0, pc: 0, run: 1'b0, ovf: 1'b0, ir: '0};
        else       m <= model_next(m);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; stop = 0; ctr_clr = 0; ovf_clr = 0; ir_clr = '0;
        pr_val = '0; mr_val = '0; mcr = '0;
        reset = 1;
        #2;
        reset = 0;
    endtask

    task automatic set_ch(input int n, input int mrv, input logic [2:0] ctl);
        mr_val[n*CW +: CW] = CW'(mrv);
        mcr[n*3 +: 3] = ctl;
    endtask

    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (tc !== 8'd0)      begin failures++; $display("FAIL reset_tc got=%0d exp=0", tc); end
        checks++; if (pc !== 8'd0)      begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        checks++; if (ir !== 4'd0)      begin failures++; $display("FAIL reset_ir got=%b exp=0000", ir); end
        checks++; if (ovf !== 1'b0)     begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
        checks++; if (irq !== 1'b0)     begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        reset = 0;
    endtask

    task automatic test_prescale();
        do_reset();
        pr_val = 8'd2;
        pulse_start();
        checks++; if (running !== 1'b1 || tc !== 8'd0 || pc !== 8'd0) begin
            failures++; $display("FAIL prescale_start running=%b tc=%0d pc=%0d exp 1/0/0", running, tc, pc);
        end
        for (int n = 1; n <= 9; n++) begin
            step();
            checks++; if (tc !== 8'(n / 3) || pc !== 8'(n % 3)) begin
                failures++; $display("FAIL prescale_n%0d tc=%0d pc=%0d exp %0d/%0d", n, tc, pc, n / 3, n % 3);
            end
        end
    endtask

    task automatic test_periodic();
        logic exp_ir;
        do_reset();
        set_ch(0, 5, 3'b011);
        pulse_start();
        for (int n = 1; n <= 14; n++) begin
            ir_clr[0] = (n == 8);
            step();
            ir_clr[0] = 1'b0;
            exp_ir = (n >= 6 && n < 8) || (n >= 12);
            checks++; if (tc !== 8'(n % 6) || ir[0] !== exp_ir || irq !== exp_ir) begin
                failures++;
                $display("FAIL periodic_n%0d tc=%0d ir0=%b irq=%b exp %0d/%b/%b", n, tc, ir[0], irq, n % 6, exp_ir, exp_ir);
            end
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        set_ch(1, 3, 3'b101);
        pulse_start();
        repeat (4) step();
        checks++; if (running !== 1'b0 || tc !== 8'd4 || pc !== 8'd0 || ir !== 4'b0010) begin
            failures++; $display("FAIL oneshot_stop running=%b tc=%0d pc=%0d ir=%b exp 0/4/0/0010", running, tc, pc, ir);
        end
        for (int n = 0; n < 10; n++) begin
            step();
            checks++; if (tc !== 8'd4 || running !== 1'b0) begin
                failures++; $display("FAIL oneshot_hold_%0d tc=%0d running=%b exp 4/0", n, tc, running);
            end
        end
    endtask

    task automatic test_simultaneous();
        int guard = 0;
        do_reset();
        set_ch(0, 7, 3'b001);
        set_ch(2, 7, 3'b011);
        pulse_start();
        while (tc !== 8'd7 && guard < 50) begin step(); guard++; end
        checks++; if (guard >= 50) begin failures++; $display("FAIL simul_wait tc=%0d exp 7 within 50 cycles", tc); end
        ir_clr = 4'b0001;
        step();
        ir_clr = '0;
        checks++; if (tc !== 8'd0 || ir !== 4'b0101 || irq !== 1'b1) begin
            failures++; $display("FAIL simul_match tc=%0d ir=%b irq=%b exp 0/0101/1", tc, ir, irq);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        pulse_start();
        repeat (255) step();
        checks++; if (tc !== 8'd255 || ovf !== 1'b0) begin
            failures++; $display("FAIL ovf_pre tc=%0d ovf=%b exp 255/0", tc, ovf);
        end
        step();
        checks++; if (tc !== 8'd0 || ovf !== 1'b1 || irq !== 1'b1) begin
            failures++; $display("FAIL ovf_wrap tc=%0d ovf=%b irq=%b exp 0/1/1", tc, ovf, irq);
        end
        ovf_clr = 1;
        step();
        ovf_clr = 0;
        checks++; if (tc !== 8'd1 || ovf !== 1'b0 || irq !== 1'b0) begin
            failures++; $display("FAIL ovf_clear tc=%0d ovf=%b irq=%b exp 1/0/0", tc, ovf, irq);
        end
    endtask

    task automatic test_control();
        int guard = 0;
        do_reset();
        start = 1; stop = 1;
        step();
        start = 0; stop = 0;
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL ctl_start_stop running=%b exp 0", running); end
        pr_val = 8'd1;
        set_ch(0, 5, 3'b010);
        pulse_start();
        while (!(tc === 8'd5 && pc === 8'd1) && guard < 50) begin step(); guard++; end
        checks++; if (guard >= 50) begin failures++; $display("FAIL ctl_wait tc=%0d pc=%0d exp 5/1 within 50", tc, pc); end
        ctr_clr = 1;
        step();
        ctr_clr = 0;
        checks++; if (tc !== 8'd0 || pc !== 8'd0 || running !== 1'b1) begin
            failures++; $display("FAIL ctl_clr tc=%0d pc=%0d running=%b exp 0/0/1", tc, pc, running);
        end
        set_ch(0, 0, 3'b000);
        guard = 0;
        while (tc !== 8'd50 && guard < 300) begin step(); guard++; end
        checks++; if (guard >= 300) begin failures++; $display("FAIL ctl_wait50 tc=%0d exp 50 within 300", tc); end
        reset = 1;
        #1;
        checks++; if (tc !== 8'd0 || pc !== 8'd0 || running !== 1'b0 || ir !== 4'd0 || ovf !== 1'b0 || irq !== 1'b0) begin
            failures++; $display("FAIL ctl_async_reset tc=%0d pc=%0d running=%b ir=%b ovf=%b irq=%b exp all 0",
                                 tc, pc, running, ir, ovf, irq);
        end
        #1;
        reset = 0;
    endtask

    task automatic test_random();
        logic [2*CW+NM+2:0] got, exp;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            start   = ($urandom % 8) == 0;
            stop    = ($urandom % 24) == 0;
            ctr_clr = ($urandom % 40) == 0;
            ovf_clr = ($urandom % 16) == 0;
            ir_clr  = (($urandom % 6) == 0) ? NM'($urandom) : '0;
            if (cyc % 64 == 0) begin
                pr_val = CW'($urandom_range(0, 3));
                for (int n = 0; n < NM; n++) set_ch(n, $urandom_range(0, 40), 3'($urandom));
            end
            if (($urandom % 700) == 0) begin
                reset = 1;
                #2;
                reset = 0;
            end
            step();
            got = {tc, pc, ir, ovf, running, irq};
            exp = {CW'(m.tc), CW'(m.pc), m.ir, m.ovf, m.run, (|m.ir) | m.ovf};
            checks++; if (got !== exp) begin
                failures++; $display("FAIL random_c%0d {tc,pc,ir,ovf,run,irq} got=%h exp=%h", cyc, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_periodic();
        test_oneshot();
        test_simultaneous();
        test_overflow();
        test_control();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/match_timer_n.md
Name: match_timer_n

Overview:
Parametrised prescaled match timer, successor to the fixed 32-bit/4-match timer. It has a single clock domain: the prescaler produces a tick enable, not a derived clock. NUM_MATCH match channels each carry per-channel actions: interrupt, reset TC, stop. It adds sticky interrupt flags with write-1-to-clear, an overflow flag, and explicit start/stop/clear control. It sits beside the peripheral register file, which drives configuration inputs as live values.

Parameters:
CNT_W, 32, width of timer counter TC, prescale counter PC, prescale value and match values
NUM_MATCH, 4, number of match channels (1..16)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  pulse: set running
stop  in  1  pulse: clear running
ctr_clr  in  1  pulse: synchronous clear of TC and PC
pr_val  in  CNT_W  prescale value; TC advances once every pr_val+1 clk cycles while running
mr_val  in  NUM_MATCH*CNT_W  match values; channel n at bits [n*CNT_W +: CNT_W]
mcr  in  NUM_MATCH*3  per-channel control; channel n bits [n*3 +: 3] = {stop, rst, int}
ir_clr  in  NUM_MATCH  write-1-to-clear for ir bits
ovf_clr  in  1  clear ovf
tc  out  CNT_W  timer counter
pc  out  CNT_W  prescale counter
ir  out  NUM_MATCH  sticky match interrupt flags
ovf  out  1  sticky TC wrap flag
irq  out  1  OR of ir and ovf
running  out  1  counter enabled

Behaviour:
- Reset state: tc=0, pc=0, ir=0, ovf=0, running=0; irq=0 follows.
- Reset is asynchronous; a reset mid-count abandons all state immediately.
- running: start sets it next cycle; stop clears it next cycle.
  - start and stop in the same cycle: stop wins.
  - A stop-match (below) clears running, with the same priority as stop.
- tick = running && (pc == pr_val).
- While running:
  - If pc != pr_val: pc <= pc+1.
  - On tick: pc <= 0 and TC updates.
  - If pr_val is lowered below the current pc, pc counts up to all-ones, wraps to 0, then matches normally. No special handling.
- While not running, pc and tc hold.
- match[n] = tick && (tc == mr_val[n]). A match is evaluated only on tick cycles, so each TC value matches at most once per pass.
- TC update on tick:
  - If any match[n] has rst set: tc <= 0.
  - Otherwise tc <= tc+1, with modulo 2^CNT_W wrap.
  - A wrap from all-ones to 0 sets ovf. A match-reset to 0 does not set ovf.
- Stop action: match[n] with stop set means running <= 0 and pc <= 0. tc takes its tick update in the same cycle, so rst and stop together leave tc=0, pc=0, stopped.
- Interrupt action: match[n] with int set means ir[n] <= 1 next cycle.
  - Flags are sticky. ir_clr[n] clears bit n.
  - Set and clear in the same cycle: set wins. The same rule applies to ovf and ovf_clr.
- Multiple channels may match in one tick. All their actions apply: rst is ORed, stop is ORed, each int sets its own flag.
- ctr_clr: tc <= 0, pc <= 0 next cycle.
  - Overrides the tick update and all rst actions.
  - Does not change running, ir or ovf.
  - Match actions other than rst (int, stop) still apply in a ctr_clr cycle.
- Latency: all outputs are registered. A match on cycle k is visible in ir/tc/running at k+1. irq is combinational from registers.
- mr_val, pr_val and mcr are sampled every cycle. Software changes take effect on the next comparison.

Decomposition:
- Shared package timer_pkg:
  - MCR field indices MCR_INT=0, MCR_RST=1, MCR_STOP=2.
  - MCR_W=3.
- One sub-module, match_channel (parameter CNT_W). Inputs tc, mr, mcr field, tick, ir_clr. Outputs match_rst, match_stop, and registered ir bit.
- Top instantiates NUM_MATCH copies in a generate loop.
- Top owns the prescaler, TC, running, ovf and action OR-reduction.

Test Plan:
1. Basic prescale: pr_val=2, start, no mcr bits → tc goes 0→1 after 3 cycles and increments every 3 cycles; pc cycles 0,1,2.
2. Periodic reset + interrupt: pr_val=0, mr0=5, mcr0={0,1,1}, start → tc sequence 0..5,0..5 repeating; ir[0] set one cycle after the tc==5 tick; ir_clr[0] clears it; irq tracks.
3. One-shot stop: pr_val=0, mr1=3, mcr1={1,0,1} → running=0, tc=4, pc=0, ir[1]=1; tc holds at 4 for 10 further cycles.
4. Simultaneous matches: mr0=mr2=7, mcr0={0,0,1}, mcr2={0,1,1} → ir[0] and ir[2] both set in the same cycle; tc 7→0. Also ir_clr[0] asserted on that match cycle: ir[0] stays 1.
5. Overflow: CNT_W=8, NUM_MATCH=2, pr_val=0, no match bits, run 256 ticks → tc wraps 255→0, ovf=1, irq=1. ovf_clr clears it.
6. Control edges: start and stop in the same cycle → running=0. ctr_clr on a tick with a rst-match → tc=0, pc=0, running unchanged. Async reset while tc=50 → all outputs 0 immediately.
